// File: rtl/slow_divider_param.sv
// Sequential restoring divider producing one quotient bit per clock, signed or unsigned per operation.
// Latency: valid pulses WIDTH+3 cycles after an accepted start, or 2 cycles after start when the divisor is zero.
// No backpressure: start is accepted only in IDLE/DONE and ignored while busy; results hold until the next accepted start.
module slow_divider_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Most negative two's-complement value; dividing it by -1 is the only signed overflow case.
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    // Counter counts down to zero, so WIDTH iterations start from WIDTH-1.
    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_busy;
    logic             w_valid;

    // Operands captured at start
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_signed;

    // Iteration state: r_dvd shifts dividend bits out of the top and quotient bits in at the bottom
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;

    // Held results
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_y_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_x_mag;
    logic [WIDTH-1:0] w_y_mag;
    logic [WIDTH:0]   w_acc_sh;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_acc_sub;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_ovf_fix;

    assign w_y_zero = (r_y == '0);
    assign w_last   = (r_cnt == '0);

    // Operand magnitudes; in unsigned mode the raw bits are already the magnitude.
    assign w_x_mag  = (r_signed && r_x[WIDTH-1]) ? -r_x : r_x;
    assign w_y_mag  = (r_signed && r_y[WIDTH-1]) ? -r_y : r_y;

    // One restoring step: the (WIDTH+1)-bit partial remainder is the old remainder shifted
    // left with the next dividend bit appended. The difference always fits in WIDTH bits
    // when the subtraction is taken, so the narrow subtract is exact.
    assign w_acc_sh  = {r_acc, r_dvd[WIDTH-1]};
    assign w_q_bit   = (w_acc_sh >= {1'b0, r_div});
    assign w_acc_sub = w_acc_sh[WIDTH-1:0] - r_div;

    // Sign fix-up: truncation toward zero, remainder follows the dividend's sign.
    // MIN/-1 needs no special quotient handling: magnitude 2^(WIDTH-1) with positive
    // sign wraps to MIN by itself; only the flag has to be raised.
    assign w_quot_fix = r_sign_q ? -r_dvd : r_dvd;
    assign w_rem_fix  = r_sign_r ? -r_acc : r_acc;
    assign w_ovf_fix  = r_signed && (r_x == MIN_NEG) && (r_y == '1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                w_busy = 1'b1;
                w_next = w_y_zero ? S_DONE : S_ITER;
            end
            S_ITER: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_valid = 1'b1;
                w_next  = start ? S_PREP : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_signed <= 1'b0;
            r_dvd    <= '0;
            r_div    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_x      <= X;
                        r_y      <= Y;
                        r_signed <= signed_mode;
                        r_dbz    <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (w_y_zero) begin
                        r_quot <= '1;
                        r_rem  <= r_x;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_dvd    <= w_x_mag;
                        r_div    <= w_y_mag;
                        r_acc    <= '0;
                        r_cnt    <= CNT_INIT;
                        r_sign_q <= r_signed && (r_x[WIDTH-1] ^ r_y[WIDTH-1]);
                        r_sign_r <= r_signed && r_x[WIDTH-1];
                    end
                end
                S_ITER: begin
                    r_acc <= w_q_bit ? w_acc_sub : w_acc_sh[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                    r_ovf  <= w_ovf_fix;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = w_busy;
    assign valid       = w_valid;
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;
    assign ovf         = r_ovf;

endmodule
